// File: rtl/cipher_stream_arbiter.sv
// Round-robin message arbiter feeding one case-preserving shift-cipher datapath.
// Define CIPHER_STATS_EN to add per-source message counters and a truncation counter.
//
// state | meaning
// IDLE  | no grant; picks the next message owner (takes one cycle)
// ENC   | encrypt port owns the datapath until its message ends
// DEC   | decrypt port owns the datapath until its message ends
module cipher_stream_arbiter #(
  parameter int MSG_LEN = 6,
  parameter int SHIFT   = 3,
  parameter int CNT_W   = $clog2(MSG_LEN + 1)
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enc_valid,
  output logic       enc_ready,
  input  logic [7:0] enc_data,
  input  logic       enc_last,
  input  logic       dec_valid,
  output logic       dec_ready,
  input  logic [7:0] dec_data,
  input  logic       dec_case,
  input  logic       dec_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_case,
  output logic       out_src,
  output logic       out_last,
  output logic       out_trunc
`ifdef CIPHER_STATS_EN
  ,
  output logic [15:0] enc_msg_cnt,
  output logic [15:0] dec_msg_cnt,
  output logic [15:0] trunc_cnt
`endif
);

  typedef enum logic [1:0] {IDLE = 2'd0, ENC = 2'd1, DEC = 2'd2} state_t;

  localparam logic [5:0]       SHIFT6   = 6'(SHIFT);
  localparam logic [5:0]       UNSHIFT6 = 6'(26 - SHIFT);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(MSG_LEN - 1);

  state_t           state_q, state_d;
  logic             rr_q, rr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_case_q, out_case_d;
  logic             out_src_q, out_src_d;
  logic             out_last_q, out_last_d;
  logic             out_trunc_q, out_trunc_d;

  // Inputs are at most 25 and the shift at most 26, so one subtract reduces mod 26.
  function automatic logic [5:0] mod26(input logic [5:0] s);
    return (s >= 6'd26) ? s - 6'd26 : s;
  endfunction

  logic       enc_up, enc_lo, dec_up;
  logic [5:0] enc_idx, enc_sum, dec_idx, dec_sum;
  logic [7:0] enc_xf, dec_xf;

  assign enc_up  = (enc_data >= 8'h41) && (enc_data <= 8'h5a);
  assign enc_lo  = (enc_data >= 8'h61) && (enc_data <= 8'h7a);
  assign dec_up  = (dec_data >= 8'h41) && (dec_data <= 8'h5a);
  assign enc_idx = enc_lo ? 6'(enc_data - 8'h61) : 6'(enc_data - 8'h41);
  assign enc_sum = mod26(enc_idx + SHIFT6);
  assign dec_idx = 6'(dec_data - 8'h41);
  assign dec_sum = mod26(dec_idx + UNSHIFT6);
  assign enc_xf  = (enc_up || enc_lo) ? 8'h41 + {2'b00, enc_sum} : enc_data;
  assign dec_xf  = dec_up ? (dec_case ? 8'h61 : 8'h41) + {2'b00, dec_sum} : dec_data;

  logic out_free, acc, acc_last, msg_end;

  assign out_free  = !out_valid_q || out_ready;
  assign enc_ready = (state_q == ENC) && enc_valid && out_free;
  assign dec_ready = (state_q == DEC) && dec_valid && out_free;
  assign acc       = enc_ready || dec_ready;
  assign acc_last  = (state_q == ENC) ? enc_last : dec_last;
  assign msg_end   = acc_last || (cnt_q == CNT_END);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_case_d  = out_case_q;
    out_src_d   = out_src_q;
    out_last_d  = out_last_q;
    out_trunc_d = out_trunc_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (enc_valid && dec_valid) begin
          state_d = rr_q ? DEC : ENC;
          rr_d    = !rr_q;
        end else if (enc_valid) begin
          state_d = ENC;
        end else if (dec_valid) begin
          state_d = DEC;
        end
      end
      ENC, DEC: begin
        if (acc) begin
          out_valid_d = 1'b1;
          out_data_d  = (state_q == ENC) ? enc_xf : dec_xf;
          out_case_d  = (state_q == ENC) && enc_lo;
          out_src_d   = (state_q == DEC);
          out_last_d  = msg_end;
          out_trunc_d = msg_end && !acc_last;
          if (msg_end) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CIPHER_STATS_EN
  logic [15:0] enc_msg_cnt_q, enc_msg_cnt_d;
  logic [15:0] dec_msg_cnt_q, dec_msg_cnt_d;
  logic [15:0] trunc_cnt_q, trunc_cnt_d;
  logic        last_handoff;

  assign last_handoff = out_valid_q && out_ready && out_last_q;

  always_comb begin
    enc_msg_cnt_d = enc_msg_cnt_q;
    dec_msg_cnt_d = dec_msg_cnt_q;
    trunc_cnt_d   = trunc_cnt_q;
    if (last_handoff) begin
      if (out_src_q) dec_msg_cnt_d = dec_msg_cnt_q + 16'd1;
      else           enc_msg_cnt_d = enc_msg_cnt_q + 16'd1;
      if (out_trunc_q) trunc_cnt_d = trunc_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_msg_cnt_q <= '0;
      dec_msg_cnt_q <= '0;
      trunc_cnt_q   <= '0;
    end else begin
      enc_msg_cnt_q <= enc_msg_cnt_d;
      dec_msg_cnt_q <= dec_msg_cnt_d;
      trunc_cnt_q   <= trunc_cnt_d;
    end
  end

  assign enc_msg_cnt = enc_msg_cnt_q;
  assign dec_msg_cnt = dec_msg_cnt_q;
  assign trunc_cnt   = trunc_cnt_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      out_case_q  <= 1'b0;
      out_src_q   <= 1'b0;
      out_last_q  <= 1'b0;
      out_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_case_q  <= out_case_d;
      out_src_q   <= out_src_d;
      out_last_q  <= out_last_d;
      out_trunc_q <= out_trunc_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_case  = out_case_q;
  assign out_src   = out_src_q;
  assign out_last  = out_last_q;
  assign out_trunc = out_trunc_q;

endmodule

// File: doc/cipher_stream_arbiter.md
Name: cipher_stream_arbiter

Overview:
- Sequences the case-preserving shift cipher as a streaming, clocked resource shared between two requesters: an encrypt port and a decrypt port.
- Grants whole messages in round-robin order and serialises bytes through one shift datapath.
- Emits one byte per cycle with its case bit and source tag.
- Sits between the message sources and the downstream sink.

Parameters:
- MSG_LEN, 6: maximum bytes per message; the message is force-terminated at this count.
- SHIFT, 3: cipher shift amount, legal range 0..25.
- CNT_W, $clog2(MSG_LEN+1): width of the byte counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- enc_valid  input  1  encrypt requester byte valid.
- enc_ready  output  1  encrypt byte accepted this cycle.
- enc_data  input  8  plaintext byte.
- enc_last  input  1  final byte of the encrypt message.
- dec_valid  input  1  decrypt requester byte valid.
- dec_ready  output  1  decrypt byte accepted this cycle.
- dec_data  input  8  ciphertext byte.
- dec_case  input  1  case bit paired with dec_data (1 = original was lowercase).
- dec_last  input  1  final byte of the decrypt message.
- out_valid  output  1  output byte valid.
- out_ready  input  1  sink accepts the output byte.
- out_data  output  8  transformed byte.
- out_case  output  1  case bit (encrypt: produced; decrypt: always 0).
- out_src  output  1  0 = encrypt message, 1 = decrypt message.
- out_last  output  1  last byte of the message.
- out_trunc  output  1  set with out_last when the message was cut at MSG_LEN.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; round-robin pointer favours encrypt; byte counter 0.
- FSM states: IDLE, ENC, DEC.
- IDLE, only enc_valid: go to ENC.
- IDLE, only dec_valid: go to DEC.
- IDLE, both valid: grant the side the pointer favours, then flip the pointer to favour the other side.
- Grant decision in IDLE takes one cycle. No byte is accepted in IDLE.
- ENC/DEC: the grant is held for the whole message; the other port's ready stays 0.
- Byte acceptance: granted_ready = granted_valid && (!out_valid || out_ready).
- Accepted byte is transformed and registered into the output stage next cycle (latency 1).
- Back-to-back throughput is 1 byte/cycle while out_ready=1.
- Output stage holds data stable while out_valid && !out_ready.
- Message end condition: accepted byte has last=1, OR counter == MSG_LEN-1.
- At message end: set out_last; out_trunc=1 only if the count limit ended it with last=0. Return to IDLE, clear the counter.
- Requester bytes after a truncation belong to a new message and rearbitrate normally.
- Encrypt, 'A'..'Z': out = 'A' + (c-'A'+SHIFT) mod 26, case 0.
- Encrypt, 'a'..'z': out = 'A' + (c-'a'+SHIFT) mod 26, case 1.
- Encrypt, other bytes: pass through unchanged, case 0.
- Decrypt, 'A'..'Z': r = (c-'A'+26-SHIFT) mod 26; out = 'a'+r if dec_case, else 'A'+r.
- Decrypt, other bytes: pass through unchanged.
- Arithmetic: mod 26 uses a single conditional subtract on a 6-bit sum, no divider.
- Reset mid-message: asserting rst_n=0 discards any in-flight byte and drops out_valid immediately (asynchronous). The partial message is not resumed.

Optional Feature:
- Macro: CIPHER_STATS_EN.
- When defined, adds outputs enc_msg_cnt[15:0], dec_msg_cnt[15:0] and trunc_cnt[15:0].
- Counters increment when a byte with out_last is handed off (out_valid && out_ready).
- Counters wrap at 0xFFFF and reset to 0.
- When undefined, these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset: hold rst_n=0, drive enc_valid=1 -> all outputs 0, enc_ready=0. Release -> first out_valid no earlier than 2 cycles later.
- Encrypt "HeLloW", last on 'W', out_ready=1 -> out_data "KHOORZ", out_case 0,1,0,1,1,0, out_src=0, out_last only on 'Z', out_trunc=0.
- Decrypt "KHOORZ" with case 0,1,0,1,1,0 -> "HeLloW", out_src=1. Wrap cases: decrypt 'A' case 1 -> 'x'; encrypt 'z' -> 'C' case 1; '!' passes through unchanged.
- Both requesters valid from IDLE after reset -> full encrypt message first, then decrypt. Repeat -> decrypt served first. No byte interleaving.
- 8-byte encrypt stream with no last -> 6 bytes out, 6th has out_last=1 and out_trunc=1; remaining 2 form a new message.
- out_ready toggled 1,0,0,1 mid-message -> out_data stable while stalled, enc_ready=0 during stall, no loss or duplication. Pulse rst_n low mid-message -> out_valid=0 immediately, next message restarts cleanly.
